// File: rtl/bin_gray_codec.sv
// Binary/Gray encoder-decoder with registered outputs and Gray-successor.
// Optional round-trip self-check enabled by GRAY_ROUNDTRIP_CHECK_EN.
module bin_gray_codec #(
  parameter int BINARY_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [BINARY_WIDTH-1:0] binary_in,
  input  logic [BINARY_WIDTH-1:0] gray_in,
  output logic [BINARY_WIDTH-1:0] gray_comb,
  output logic [BINARY_WIDTH-1:0] binary_comb,
  output logic                    out_valid,
  output logic [BINARY_WIDTH-1:0] gray_out,
  output logic [BINARY_WIDTH-1:0] binary_out,
  output logic [BINARY_WIDTH-1:0] gray_next_out,
  output logic                    check_error
);

  localparam int W = BINARY_WIDTH;

  function automatic logic [W-1:0] bin2gray(
    input logic [W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR running from the MSB downwards.
  function automatic logic [W-1:0] gray2bin(
    input logic [W-1:0] g
  );
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [W-1:0] bin_inc;

  assign gray_comb   = bin2gray(binary_in);
  assign binary_comb = gray2bin(gray_in);
  assign bin_inc     = binary_comb + W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      gray_out      <= '0;
      binary_out    <= '0;
      gray_next_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gray_out      <= gray_comb;
        binary_out    <= binary_comb;
        gray_next_out <= bin2gray(bin_inc);
      end
    end
  end

`ifdef GRAY_ROUNDTRIP_CHECK_EN
  logic [W-1:0] rt_bin;
  logic         err_q;

  assign rt_bin      = gray2bin(gray_comb);
  assign check_error = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (in_valid && (rt_bin != binary_in))
      err_q <= 1'b1;
  end
`else
  assign check_error = 1'b0;
`endif

endmodule

// File: tb/tb_bin_gray_codec.sv
// Directed-vector bench for bin_gray_codec at BINARY_WIDTH=4.
module tb_bin_gray_codec;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] binary_in = '0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] gray_comb;
  logic [W-1:0] binary_comb;
  logic         out_valid;
  logic [W-1:0] gray_out;
  logic [W-1:0] binary_out;
  logic [W-1:0] gray_next_out;
  logic         check_error;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] gtab [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8
  };

  bin_gray_codec #(.BINARY_WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .binary_in     (binary_in),
    .gray_in       (gray_in),
    .gray_comb     (gray_comb),
    .binary_comb   (binary_comb),
    .out_valid     (out_valid),
    .gray_out      (gray_out),
    .binary_out    (binary_out),
    .gray_next_out (gray_next_out),
    .check_error   (check_error)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_go", gray_out, 0);
    chk("rst_bo", binary_out, 0);
    chk("rst_gn", gray_next_out, 0);
    chk("rst_ce", check_error, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_ov", out_valid, 0);

    binary_in = 4'b1011;
    gray_in   = 4'b1110;
    in_valid  = 1'b1;
    #1;
    chk("gc_1011", gray_comb, 4'b1110);
    chk("bc_1110", binary_comb, 4'b1011);
    tick();
    chk("ov_1", out_valid, 1);
    chk("go_1", gray_out, 4'b1110);
    chk("bo_1", binary_out, 4'b1011);
    chk("gn_1", gray_next_out, 4'b1010);

    binary_in = 4'b0000;
    gray_in   = 4'b1000;
    tick();
    chk("bo_wrap", binary_out, 4'b1111);
    chk("gn_wrap", gray_next_out, 4'b0000);
    chk("go_zero", gray_out, 4'b0000);

    for (int v = 0; v < 16; v++) begin
      binary_in = W'(v);
      gray_in   = gtab[v];
      #1;
      chk("sw_gc", gray_comb, gtab[v]);
      chk("sw_bc", binary_comb, v);
      tick();
      chk("sw_ov", out_valid, 1);
      chk("sw_bo", binary_out, v);
      chk("sw_gn", gray_next_out, gtab[(v + 1) % 16]);
      chk("sw_1bit", $countones(gray_out ^ gray_next_out), 1);
    end
    chk("sw_ce", check_error, 0);

    binary_in = 4'b0101;
    gray_in   = 4'b0011;
    tick();
    in_valid  = 1'b0;
    binary_in = 4'b1111;
    gray_in   = 4'b1111;
    chk("pl_ov", out_valid, 1);
    chk("pl_go", gray_out, 4'b0111);
    chk("pl_bo", binary_out, 4'b0010);
    chk("pl_gn", gray_next_out, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_ov", out_valid, 0);
      chk("hold_go", gray_out, 4'b0111);
      chk("hold_bo", binary_out, 4'b0010);
      chk("hold_gn", gray_next_out, 4'b0010);
    end

    binary_in = 4'b1011;
    gray_in   = 4'b1110;
    in_valid  = 1'b1;
    tick();
    chk("mr_ov_pre", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_go", gray_out, 0);
    chk("mr_bo", binary_out, 0);
    chk("mr_gn", gray_next_out, 0);
    chk("mr_gc", gray_comb, 4'b1110);
    chk("mr_bc", binary_comb, 4'b1011);
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    chk("post_ov", out_valid, 0);
    tick();
    chk("post_ov2", out_valid, 0);
    in_valid = 1'b1;
    tick();
    chk("post_ov3", out_valid, 1);
    chk("post_go", gray_out, 4'b1110);
    in_valid = 1'b0;
    tick();
    chk("end_ce", check_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
